// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Opcode/funct values follow the MIPS32 instruction encoding.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Coarse ALU request from the FSM; FUNCT defers to the instruction's funct field.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: maps the FSM's coarse alu_op plus funct to the ALU
// control code, flagging R-type funct values the ALU does not implement.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for the shared-memory multicycle MIPS datapath.
// Only ir_write/pc_en/illegal_op look at inputs within the current state.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     state;
  state_t     state_next;
  logic       rdy;
  logic [1:0] alu_op;
  logic       funct_illegal;
  logic       mem_req_c, mem_write_c, ir_write_c, reg_write_c;
  logic       pc_write, branch, illegal_c;

  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Kept apart from the main decode so funct_illegal never feeds back into alu_op.
  always_comb begin
    case (state)
      S_EXECUTE: alu_op = ALUOP_FUNCT;
      S_BRANCH:  alu_op = ALUOP_SUB;
      default:   alu_op = ALUOP_ADD;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_next  = S_FETCH;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal_c   = 1'b0;
    iord        = 1'b0;
    pc_src      = PCSRC_ALU;
    reg_dest    = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_FOUR;
    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ir_write_c = rdy;
        pc_write   = rdy;
        state_next = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      illegal_c  = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c  = 1'b1;
        iord       = 1'b1;
        state_next = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        iord        = 1'b1;
        state_next  = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        illegal_c  = funct_illegal;
        state_next = funct_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dest    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: reg_write_c = 1'b1;
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Side-effecting strobes are masked for the whole reset pulse, not just after the edge.
  assign mem_req    = mem_req_c & ~reset;
  assign mem_write  = mem_write_c & ~reset;
  assign ir_write   = ir_write_c & ~reset;
  assign reg_write  = reg_write_c & ~reset;
  assign illegal_op = illegal_c & ~reset;
  assign pc_en      = (pc_write | (branch & zero_flag)) & ~reset;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl; a per-instruction model
// predicts the state trace and per-instruction strobe totals.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       reg_dest, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILLOP = 6, K_BADF = 7;

  logic [3:0] exp_q[$];
  bit         rdy_q[$];
  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [5:0] op_of(input int kind);
    case (kind)
      K_LW:    return 6'h23;
      K_SW:    return 6'h2b;
      K_BEQ:   return 6'h04;
      K_ADDI:  return 6'h08;
      K_J:     return 6'h02;
      default: return 6'h00;
    endcase
  endfunction

  task automatic push(input int s, input bit r);
    exp_q.push_back(4'(s));
    rdy_q.push_back(r);
  endtask

  // Reference path: f fetch stalls, d data-phase stalls; ready is random where it must not matter.
  task automatic build(input int kind, input int f, input int d);
    exp_q.delete();
    rdy_q.delete();
    repeat (f) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom_range(0, 1)));
    case (kind)
      K_R:    begin push(6, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
      K_BADF: push(6, 1'($urandom_range(0, 1)));
      K_LW: begin
        push(2, 1'($urandom_range(0, 1)));
        repeat (d) push(3, 1'b0);
        push(3, 1'b1);
        push(4, 1'($urandom_range(0, 1)));
      end
      K_SW: begin
        push(2, 1'($urandom_range(0, 1)));
        repeat (d) push(5, 1'b0);
        push(5, 1'b1);
      end
      K_BEQ:  push(8, 1'($urandom_range(0, 1)));
      K_ADDI: begin push(9, 1'($urandom_range(0, 1))); push(10, 1'($urandom_range(0, 1))); end
      K_J:    push(11, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  // Entered at a rising edge with the DUT in FETCH; returns at the edge that ends the instruction.
  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int f, input int d, input int abort_at);
    int n_rw, n_mw, n_ill, n_pc, n_ir;
    logic [3:0] s;
    n_rw = 0; n_mw = 0; n_ill = 0; n_pc = 0; n_ir = 0;
    build(kind, f, d);
    foreach (exp_q[c]) begin
      #1;
      opcode = op; funct = fn; zero_flag = zero; mem_ready = rdy_q[c];
      #1;
      s = exp_q[c];
      chkv("state", 8'(state_o), 8'(s));
      n_rw  += int'(reg_write);
      n_mw  += int'(mem_write);
      n_ill += int'(illegal_op);
      n_pc  += int'(pc_en);
      n_ir  += int'(ir_write);
      case (s)
        4'd0: begin
          chk1("fetch_mem_req", mem_req, 1'b1);
          chk1("fetch_iord", iord, 1'b0);
          chk1("fetch_ir_write", ir_write, rdy_q[c]);
          chk1("fetch_pc_en", pc_en, rdy_q[c]);
          chk1("fetch_src_a", alu_src_a, 1'b0);
          chkv("fetch_src_b", 8'(alu_src_b), 8'h1);
          chkv("fetch_alu", 8'(alu_control), 8'h2);
        end
        4'd1: begin
          chk1("decode_illegal", illegal_op, kind == K_ILLOP);
          chkv("decode_src_b", 8'(alu_src_b), 8'h3);
          chk1("decode_mem_req", mem_req, 1'b0);
        end
        4'd2: begin
          chk1("memadr_src_a", alu_src_a, 1'b1);
          chkv("memadr_src_b", 8'(alu_src_b), 8'h2);
        end
        4'd3: begin
          chk1("memread_req", mem_req, 1'b1);
          chk1("memread_iord", iord, 1'b1);
          chk1("memread_wr", mem_write, 1'b0);
        end
        4'd4: begin
          chk1("memwb_rw", reg_write, 1'b1);
          chk1("memwb_m2r", mem_to_reg, 1'b1);
          chk1("memwb_dest", reg_dest, 1'b0);
        end
        4'd5: begin
          chk1("memwrite_req", mem_req, 1'b1);
          chk1("memwrite_iord", iord, 1'b1);
          chk1("memwrite_wr", mem_write, 1'b1);
        end
        4'd6: begin
          chkv("exec_alu", 8'(alu_control), 8'(alu_of(fn)));
          chk1("exec_illegal", illegal_op, kind == K_BADF);
          chk1("exec_src_a", alu_src_a, 1'b1);
          chkv("exec_src_b", 8'(alu_src_b), 8'h0);
        end
        4'd7: begin
          chk1("aluwb_rw", reg_write, 1'b1);
          chk1("aluwb_dest", reg_dest, 1'b1);
          chk1("aluwb_m2r", mem_to_reg, 1'b0);
        end
        4'd8: begin
          chkv("branch_alu", 8'(alu_control), 8'h6);
          chkv("branch_pc_src", 8'(pc_src), 8'h1);
          chk1("branch_pc_en", pc_en, zero);
        end
        4'd9: begin
          chk1("addiex_src_a", alu_src_a, 1'b1);
          chkv("addiex_src_b", 8'(alu_src_b), 8'h2);
          chkv("addiex_alu", 8'(alu_control), 8'h2);
        end
        4'd10: begin
          chk1("addiwb_rw", reg_write, 1'b1);
          chk1("addiwb_dest", reg_dest, 1'b0);
          chk1("addiwb_m2r", mem_to_reg, 1'b0);
        end
        4'd11: begin
          chkv("jump_pc_src", 8'(pc_src), 8'h2);
          chk1("jump_pc_en", pc_en, 1'b1);
        end
        default: ;
      endcase
      if (c == abort_at) begin
        #1 reset = 1'b1;
        #1;
        chkv("abort_state", 8'(state_o), 8'h0);
        chk1("abort_mem_write", mem_write, 1'b0);
        chk1("abort_mem_req", mem_req, 1'b0);
        chk1("abort_ir_write", ir_write, 1'b0);
        @(posedge clk);
        #1;
        chkv("abort_state_held", 8'(state_o), 8'h0);
        chk1("abort_mem_req_held", mem_req, 1'b0);
        chk1("abort_reg_write_held", reg_write, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        return;
      end
      @(posedge clk);
    end
    chkv("n_reg_write", 8'(n_rw), 8'((kind == K_R || kind == K_LW || kind == K_ADDI) ? 1 : 0));
    chkv("n_mem_write", 8'(n_mw), 8'((kind == K_SW) ? d + 1 : 0));
    chkv("n_illegal", 8'(n_ill), 8'((kind == K_ILLOP || kind == K_BADF) ? 1 : 0));
    chkv("n_pc_en", 8'(n_pc), 8'(1 + ((kind == K_BEQ && zero) ? 1 : 0) + ((kind == K_J) ? 1 : 0)));
    chkv("n_ir_write", 8'(n_ir), 8'h1);
  endtask

  initial begin
    int k, f, d;
    logic [5:0] op, fn;
    reset = 1'b1; opcode = 6'h0; funct = 6'h20; zero_flag = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    chkv("rst_state", 8'(state_o), 8'h0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_ir_write", ir_write, 1'b0);
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_reg_write", reg_write, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_illegal", illegal_op, 1'b0);
    chkv("rst_src_b", 8'(alu_src_b), 8'h1);
    chkv("rst_alu", 8'(alu_control), 8'h2);
    chkv("rst_pc_src", 8'(pc_src), 8'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);

    run_instr(K_R,     6'h00, 6'h20, 1'b0, 0, 0, -1);
    run_instr(K_LW,    6'h23, 6'h20, 1'b0, 0, 2, -1);
    run_instr(K_BEQ,   6'h04, 6'h20, 1'b1, 0, 0, -1);
    run_instr(K_BEQ,   6'h04, 6'h20, 1'b0, 0, 0, -1);
    run_instr(K_SW,    6'h2b, 6'h20, 1'b0, 0, 1, -1);
    run_instr(K_ILLOP, 6'h3f, 6'h20, 1'b0, 0, 0, -1);
    run_instr(K_BADF,  6'h00, 6'h01, 1'b0, 0, 0, -1);
    run_instr(K_ADDI,  6'h08, 6'h20, 1'b0, 0, 0, -1);
    run_instr(K_J,     6'h02, 6'h20, 1'b0, 0, 0, -1);
    run_instr(K_R,     6'h00, 6'h22, 1'b0, 2, 0, -1);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 7);
      f = $urandom_range(0, 2);
      d = $urandom_range(0, 2);
      fn = fn_tab[$urandom_range(0, 4)];
      op = op_of(k);
      if (k == K_ILLOP) begin
        do op = 6'($urandom); while (is_legal_op(op));
      end
      if (k == K_BADF) begin
        do fn = 6'($urandom); while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
      end
      run_instr(k, op, fn, 1'($urandom_range(0, 1)), f, d, -1);
    end

    // sw stalled in MEMWRITE, aborted by reset in its first MEMWRITE cycle.
    run_instr(K_SW, 6'h2b, 6'h20, 1'b0, 0, 3, 3);
    run_instr(K_R,  6'h00, 6'h2a, 1'b0, 0, 0, -1);

    #1 mem_ready = 1'b0;
    #1 chkv("final_state", 8'(state_o), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
